// File: rtl/bu2020_pkg.sv
// bu2020_pkg
//   Shared types and constants for the BU2020 core front end.
//   ADDR_W      : byte address width of the shared address bus
//   DATA_W      : instruction / data bus width
//   INSTR_BYTES : bytes per instruction word (sequential pc stride)
//   fetch_entry_t : {pc, data} record carried through the prefetch FIFO
package bu2020_pkg;

    localparam int ADDR_W      = 12;
    localparam int DATA_W      = 16;
    localparam int INSTR_BYTES = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Instructions are halfword aligned; the low address bit is dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
        return a & {{(ADDR_W-1){1'b1}}, 1'b0};
    endfunction

endpackage

// File: rtl/bu2020_sync_fifo.sv
// bu2020_sync_fifo
//   Synchronous first-word-fall-through FIFO with flush.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   flush_i      : empty the FIFO; wins over push and pop in the same cycle
//   push_i       : write push_data_i at the closing edge
//   push_data_i  : entry to write
//   pop_i        : drop the head at the closing edge (ignored while empty)
//   head_data_o  : head entry, valid whenever count_o != 0
//   count_o      : number of stored entries, 0..DEPTH
module bu2020_sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic             full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !flush_i;
    // A pop against an empty FIFO would corrupt the pointers, so gate it here.
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    // Callers must guarantee room before pushing.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(do_push && full));

endmodule

// File: rtl/bu2020_fetch_unit.sv
// bu2020_fetch_unit
//   Instruction prefetch stage: issues sequential halfword reads when the
//   arbiter grants the bus, buffers {pc, data} in a FIFO and presents them
//   to decode over valid/ready. A redirect flushes everything and restarts.
//   clk, rst        : clock; synchronous active-high reset
//   mem_gnt         : bus granted to fetch this cycle
//   fetch_addr_en   : read issued this cycle
//   fetch_addr      : address of the issued read (0 when idle)
//   mem_rdata       : read data, one cycle after issue
//   redirect_valid  : flush and restart at redirect_pc
//   redirect_pc     : new fetch address (bit 0 ignored)
//   instr_valid     : head entry available
//   instr_data      : head instruction word (0 when not valid)
//   instr_pc        : head instruction address (0 when not valid)
//   instr_ready     : decode consumes the head
module bu2020_fetch_unit
    import bu2020_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_gnt,
    output logic        fetch_addr_en,
    output logic [11:0] fetch_addr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [11:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr_data,
    output logic [11:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Every outstanding read needs a guaranteed FIFO slot. Pops in the same
    // cycle are not credited, which costs at most one bubble but keeps the
    // issue path free of the decode handshake.
    assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign issue       = !rst && mem_gnt && !redirect_valid
                         && (credit_used < (CNT_W+1)'(DEPTH));

    assign fetch_addr_en = issue;
    assign fetch_addr    = issue ? pc_q : '0;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            // issue is already low here, so the pending response is dropped.
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(INSTR_BYTES);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign fifo_push       = inflight_q && !redirect_valid;
    assign fifo_pop        = instr_valid && instr_ready;
    assign push_entry.pc   = inflight_pc_q;
    assign push_entry.data = mem_rdata;

    bu2020_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_data_o (head_entry),
        .count_o     (fifo_count)
    );

    // Outputs are zeroed while empty so stale storage never leaks to decode.
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = instr_valid ? head_entry.data : '0;
    assign instr_pc    = instr_valid ? head_entry.pc   : '0;

endmodule

// File: tb/tb_bu2020_fetch_unit.sv
module tb_bu2020_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [11:0] RESET_PC = 12'h000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_gnt;
    logic        fetch_addr_en;
    logic [11:0] fetch_addr;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [11:0] instr_pc;
    logic        instr_ready;

    int n_tests = 0;
    int n_fail  = 0;

    bu2020_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_gnt        (mem_gnt),
        .fetch_addr_en  (fetch_addr_en),
        .fetch_addr     (fetch_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory model: word at addr is 16'h1000 + addr, one cycle latency;
    // garbage on idle cycles so an unexpected capture shows up.
    always @(posedge clk)
        mem_rdata <= fetch_addr_en ? (16'h1000 + {4'h0, fetch_addr}) : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [11:0] pc;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    bit          chk_en  = 0;
    int          cyc     = 0;
    int          n_deliv = 0;
    logic [11:0] exp_pc  = RESET_PC;
    bit          prev_stall = 0;
    logic [11:0] prev_pc;
    logic [15:0] prev_data;

    always @(negedge clk) begin
        bit exp_en;
        bit exp_vld;
        cyc++;
        if (chk_en) begin
            if (rst || redirect_valid) begin
                chk("mon_no_issue_on_flush", 32'(fetch_addr_en), 32'd0);
                sb.delete();
                exp_pc     = rst ? RESET_PC : {redirect_pc[11:1], 1'b0};
                prev_stall = 0;
            end else begin
                // outstanding words = fifo count + in-flight read
                exp_en  = mem_gnt && (sb.size() < DEPTH);
                exp_vld = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
                chk("mon_issue_en", 32'(fetch_addr_en), 32'(exp_en));
                chk("mon_instr_valid", 32'(instr_valid), 32'(exp_vld));
                if (prev_stall) begin
                    chk("mon_stall_pc", 32'(instr_pc), 32'(prev_pc));
                    chk("mon_stall_data", 32'(instr_data), 32'(prev_data));
                end
                if (instr_valid && instr_ready && sb.size() > 0) begin
                    chk("mon_deliv_pc", 32'(instr_pc), 32'(sb[0].pc));
                    chk("mon_deliv_data", 32'(instr_data), 32'(sb[0].data));
                    void'(sb.pop_front());
                    n_deliv++;
                end
                if (fetch_addr_en) begin
                    chk("mon_issue_addr", 32'(fetch_addr), 32'(exp_pc));
                    sb.push_back('{exp_pc, 16'h1000 + {4'h0, exp_pc}, cyc});
                    exp_pc = exp_pc + 12'd2;
                end else begin
                    chk("mon_idle_addr", 32'(fetch_addr), 32'd0);
                end
                prev_stall = instr_valid && !instr_ready;
                prev_pc    = instr_pc;
                prev_data  = instr_data;
            end
        end
    end

    // ---------------- directed tables + sequences ----------------
    typedef struct {
        bit          rst_before;
        bit          gnt;
        bit          rdy;
        bit          en;
        logic [11:0] addr;
        bit          vld;
        logic [11:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit g, bit y, bit e, logic [11:0] a, bit v, logic [11:0] p);
        vec_t t;
        t.rst_before = r; t.gnt = g; t.rdy = y; t.en = e; t.addr = a; t.vld = v; t.pc = p;
        return t;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] p;
        int          d0;

        rst = 1'b1; mem_gnt = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 12'h000;
        nxt();
        chk_en = 1;

        // startup with gnt=1, ready=1
        tbl.push_back(mk(1, 1, 1, 1, 12'h000, 0, 12'h000));
        tbl.push_back(mk(0, 1, 1, 1, 12'h002, 0, 12'h000));
        tbl.push_back(mk(0, 1, 1, 1, 12'h004, 1, 12'h000));
        tbl.push_back(mk(0, 1, 1, 1, 12'h006, 1, 12'h002));
        tbl.push_back(mk(0, 1, 1, 1, 12'h008, 1, 12'h004));
        tbl.push_back(mk(0, 1, 1, 1, 12'h00A, 1, 12'h006));
        // decode stalled from reset, then one consume
        tbl.push_back(mk(1, 1, 0, 1, 12'h000, 0, 12'h000));
        tbl.push_back(mk(0, 1, 0, 1, 12'h002, 0, 12'h000));
        tbl.push_back(mk(0, 1, 0, 1, 12'h004, 1, 12'h000));
        tbl.push_back(mk(0, 1, 0, 1, 12'h006, 1, 12'h000));
        tbl.push_back(mk(0, 1, 0, 0, 12'h000, 1, 12'h000));
        tbl.push_back(mk(0, 1, 0, 0, 12'h000, 1, 12'h000));
        tbl.push_back(mk(0, 1, 0, 0, 12'h000, 1, 12'h000));
        tbl.push_back(mk(0, 1, 1, 0, 12'h000, 1, 12'h000));
        tbl.push_back(mk(0, 1, 0, 1, 12'h008, 1, 12'h002));
        tbl.push_back(mk(0, 1, 0, 0, 12'h000, 1, 12'h002));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) do_reset();
            mem_gnt     = tbl[i].gnt;
            instr_ready = tbl[i].rdy;
            smp();
            chk($sformatf("tbl%0d_en", i),   32'(fetch_addr_en), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_addr", i), 32'(fetch_addr),    32'(tbl[i].addr));
            chk($sformatf("tbl%0d_vld", i),  32'(instr_valid),   32'(tbl[i].vld));
            chk($sformatf("tbl%0d_pc", i),   32'(instr_pc),      32'(tbl[i].pc));
            chk($sformatf("tbl%0d_data", i), 32'(instr_data),
                32'(tbl[i].vld ? 16'h1000 + {4'h0, tbl[i].pc} : 16'h0000));
            nxt();
        end
        smp();
        chk("stall_count_full", 32'(dut.fifo_count), 32'(DEPTH));
        chk("stall_no_issue", 32'(fetch_addr_en), 32'd0);
        nxt();

        // redirect with 3 buffered words and one in flight
        do_reset();
        mem_gnt = 1'b1; instr_ready = 1'b0;
        repeat (4) nxt();
        redirect_valid = 1'b1; redirect_pc = 12'h135;
        smp();
        chk("redir_pre_count", 32'(dut.fifo_count), 32'd3);
        chk("redir_pre_inflight", 32'(dut.inflight_q), 32'd1);
        nxt();
        redirect_valid = 1'b0; instr_ready = 1'b1;
        smp();
        chk("redir_count0", 32'(dut.fifo_count), 32'd0);
        chk("redir_vld0", 32'(instr_valid), 32'd0);
        chk("redir_issue_addr", 32'(fetch_addr), 32'h134);
        nxt(); smp();
        chk("redir_vld_c2", 32'(instr_valid), 32'd0);
        nxt(); smp();
        chk("redir_vld_c3", 32'(instr_valid), 32'd1);
        chk("redir_pc_c3", 32'(instr_pc), 32'h134);
        chk("redir_data_c3", 32'(instr_data), 32'h1134);
        nxt();

        // wrap past the top of the address space
        redirect_valid = 1'b1; redirect_pc = 12'hFFC;
        nxt();
        redirect_valid = 1'b0;
        nxt(); nxt();
        p = 12'hFFC;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("wrap%0d_vld", k), 32'(instr_valid), 32'd1);
            chk($sformatf("wrap%0d_pc", k), 32'(instr_pc), 32'(p));
            p = p + 12'd2;
            nxt();
        end

        // intermittent grant
        do_reset();
        instr_ready = 1'b1;
        d0 = n_deliv;
        for (int r = 0; r < 3; r++) begin
            mem_gnt = 1'b1; nxt();
            mem_gnt = 1'b0; nxt();
            nxt();
            mem_gnt = 1'b1; nxt();
        end
        mem_gnt = 1'b0;
        repeat (4) nxt();
        chk("gnt_toggle_deliveries", 32'(n_deliv - d0), 32'd6);

        // reset while busy
        do_reset();
        mem_gnt = 1'b1; instr_ready = 1'b0;
        repeat (3) nxt();
        rst = 1'b1;
        smp();
        chk("rst_mid_busy", 32'(dut.fifo_count), 32'd2);
        nxt();
        rst = 1'b0; instr_ready = 1'b1;
        smp();
        chk("rst_vld0", 32'(instr_valid), 32'd0);
        chk("rst_count0", 32'(dut.fifo_count), 32'd0);
        chk("rst_issue_addr", 32'(fetch_addr), 32'(RESET_PC));
        nxt(); nxt(); smp();
        chk("rst_first_vld", 32'(instr_valid), 32'd1);
        chk("rst_first_pc", 32'(instr_pc), 32'(RESET_PC));
        chk("rst_first_data", 32'(instr_data), 32'(16'h1000 + {4'h0, RESET_PC}));
        nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
